// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | systolic_array_ctrl: fetches operand rows, streams them into a systolic
// | array, collects the result rows and writes them out.   Revision 1.0
// +----------------------------------------------------------------------------
module systolic_array_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5,
  parameter int TIMEOUT   = 64,
  localparam int AW       = (N_SIZE > 1) ? $clog2(N_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_err,
  output logic                            op_rd_en,
  output logic [AW-1:0]                   op_rd_addr,
  input  logic [N_SIZE*DATAWIDTH-1:0]     op_a_data,
  input  logic [N_SIZE*DATAWIDTH-1:0]     op_b_data,
  output logic                            sa_valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0]     sa_a,
  output logic [N_SIZE*DATAWIDTH-1:0]     sa_b,
  input  logic                            sa_valid_out,
  input  logic [N_SIZE*2*DATAWIDTH-1:0]   sa_c,
  output logic                            res_wr_en,
  output logic [AW-1:0]                   res_wr_addr,
  output logic [N_SIZE*2*DATAWIDTH-1:0]   res_wr_data
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ROW_LAST  = AW'(N_SIZE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_rd_vld;
  logic [AW-1:0] r_row;
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_vld    <= 1'b0;
      r_row       <= '0;
      r_tmo       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      op_rd_en    <= 1'b0;
      op_rd_addr  <= '0;
      sa_valid_in <= 1'b0;
      sa_a        <= '0;
      sa_b        <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      // Buffer has one cycle of read latency; the delayed strobe marks valid data.
      r_rd_vld    <= op_rd_en;
      sa_valid_in <= r_rd_vld;
      sa_a        <= r_rd_vld ? op_a_data : '0;
      sa_b        <= r_rd_vld ? op_b_data : '0;
      res_wr_en   <= 1'b0;

      if (abort) begin
        r_state     <= S_IDLE;
        r_rd_vld    <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b0;
        op_rd_en    <= 1'b0;
        op_rd_addr  <= '0;
        sa_valid_in <= 1'b0;
        sa_a        <= '0;
        sa_b        <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_row <= '0;
            r_tmo <= '0;
            if (start) begin
              r_state     <= S_FETCH;
              busy        <= 1'b1;
              timeout_err <= 1'b0;
              op_rd_en    <= 1'b1;
              op_rd_addr  <= '0;
            end
          end

          S_FETCH: begin
            if (op_rd_addr == ROW_LAST) begin
              op_rd_en <= 1'b0;
              r_tmo    <= '0;
              r_state  <= S_WAIT;
            end else begin
              op_rd_addr <= op_rd_addr + 1'b1;
            end
          end

          S_WAIT, S_DRAIN: begin
            if (sa_valid_out) begin
              r_tmo       <= '0;
              res_wr_en   <= 1'b1;
              res_wr_addr <= r_row;
              res_wr_data <= sa_c;
              if (r_row == ROW_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= S_DRAIN;
              end
            end else if (r_tmo == TMO_LAST) begin
              timeout_err <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end

          // After a normal drain the first DONE cycle carries the last write,
          // so the done pulse follows one cycle later.
          S_DONE: begin
            if (done) begin
              done    <= 1'b0;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              done <= 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// Scoreboard bench for systolic_array_ctrl with an operand buffer model and a
// behavioural array stub; expected result rows come from a matrix-product model.
module tb_systolic_array_ctrl;

  localparam int DW  = 16;
  localparam int N   = 5;
  localparam int TMO = 64;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, timeout_err, op_rd_en, sa_valid_in, res_wr_en;
  logic [AW-1:0]       op_rd_addr, res_wr_addr;
  logic [N*DW-1:0]     op_a_data, op_b_data, sa_a, sa_b;
  logic                sa_valid_out;
  logic [N*2*DW-1:0]   sa_c, res_wr_data;

  systolic_array_ctrl #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
    .op_a_data(op_a_data), .op_b_data(op_b_data),
    .sa_valid_in(sa_valid_in), .sa_a(sa_a), .sa_b(sa_b),
    .sa_valid_out(sa_valid_out), .sa_c(sa_c),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- operand memories and reference model ----------------
  int unsigned mem_a [N][N];
  int unsigned mem_b [N][N];

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [N*2*DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic void push_expected();
    for (int r = 0; r < N; r++) begin
      logic [N*2*DW-1:0] row;
      row = '0;
      for (int j = 0; j < N; j++) begin
        longint unsigned acc;
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += longint'(mem_a[r][k]) * longint'(mem_b[k][j]);
        row[j*2*DW +: 2*DW] = (2*DW)'(acc);
      end
      sb.push_back('{addr: AW'(r), data: row});
    end
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Operand buffer: one cycle read latency; garbage when not read.
  initial begin
    op_a_data = '0;
    op_b_data = '0;
    forever begin
      logic          en;
      logic [AW-1:0] ad;
      @(posedge clk);
      en = op_rd_en;
      ad = op_rd_addr;
      #1;
      if (en && int'(ad) < N) begin
        for (int j = 0; j < N; j++) begin
          op_a_data[j*DW +: DW] = DW'(mem_a[ad][j]);
          op_b_data[j*DW +: DW] = DW'(mem_b[ad][j]);
        end
      end else begin
        op_a_data = rand_vec();
        op_b_data = rand_vec();
      end
    end
  end

  // ---------------- array stub ----------------
  bit  stub_stuck = 1'b0;
  int  stub_gap   = 0;
  int  stub_lat   = 0;
  int  wait_cnt   = 0;
  logic [N*DW-1:0]   cap_a[$];
  logic [N*DW-1:0]   cap_b[$];
  logic [N*2*DW-1:0] emit_q[$];

  initial begin
    sa_valid_out = 1'b0;
    sa_c = '0;
    forever begin
      logic vin;
      logic [N*DW-1:0] va, vb;
      @(posedge clk);
      vin = sa_valid_in;
      va  = sa_a;
      vb  = sa_b;
      #1;
      if (vin) begin
        cap_a.push_back(va);
        cap_b.push_back(vb);
        if (cap_a.size() == N && !stub_stuck) begin
          for (int r = 0; r < N; r++) begin
            logic [N*2*DW-1:0] row;
            for (int j = 0; j < N; j++) begin
              longint unsigned acc;
              acc = 0;
              for (int k = 0; k < N; k++)
                acc += longint'(cap_a[r][k*DW +: DW]) * longint'(cap_b[k][j*DW +: DW]);
              row[j*2*DW +: 2*DW] = (2*DW)'(acc);
            end
            emit_q.push_back(row);
          end
          wait_cnt = stub_lat;
        end
      end
      if (emit_q.size() > 0 && wait_cnt == 0) begin
        sa_valid_out = 1'b1;
        sa_c = emit_q.pop_front();
        wait_cnt = stub_gap;
      end else begin
        sa_valid_out = 1'b0;
        sa_c = '0;
        if (wait_cnt > 0) wait_cnt--;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int rd_cnt = 0, vin_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int first_rd_cyc = 0, last_rd_cyc = 0, first_vin_cyc = 0, last_vin_cyc = 0;
  int last_wr_cyc = 0, done_cyc = 0;
  bit prev_vo = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (op_rd_en) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        chk("rd_addr", 256'(op_rd_addr), 256'(rd_cnt));
        rd_cnt++;
      end
      if (sa_valid_in) begin
        if (vin_cnt == 0) first_vin_cyc = cyc;
        last_vin_cyc = cyc;
        vin_cnt++;
      end
      if (res_wr_en) begin
        chk("wr_follows_valid_out", 256'(prev_vo), 256'(1));
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", res_wr_addr, res_wr_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", 256'(res_wr_addr), 256'(e.addr));
          chk("wr_data", 256'(res_wr_data), 256'(e.data));
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_vo = sa_valid_out;
    end else begin
      prev_vo = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  function automatic void clear_job();
    cap_a.delete();
    cap_b.delete();
    emit_q.delete();
    sb.delete();
    rd_cnt = 0; vin_cnt = 0; wr_cnt = 0; done_cnt = 0;
  endfunction

  task automatic run_job(input bit stuck, input int gap, input int lat, input bit mid_start);
    int t;
    clear_job();
    stub_stuck = stuck;
    stub_gap   = gap;
    stub_lat   = lat;
    if (!stuck) push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("err_clear_on_start", 256'(timeout_err), 256'(0));
    chk("rd_en_after_start", 256'(op_rd_en), 256'(1));
    if (mid_start) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      tick();
      t++;
    end
    chk("done_seen", 256'(done_cnt > 0), 256'(1));
    chk("busy_during_done", 256'(busy), 256'(1));
    chk("timeout_err", 256'(timeout_err), 256'(stuck));
    tick();
    chk("busy_after_done", 256'(busy), 256'(0));
    chk("done_single_pulse", 256'(done_cnt), 256'(1));
    chk("reads", 256'(rd_cnt), 256'(N));
    chk("reads_contiguous", 256'(last_rd_cyc - first_rd_cyc), 256'(N - 1));
    chk("vin_count", 256'(vin_cnt), 256'(N));
    chk("vin_latency", 256'(first_vin_cyc - first_rd_cyc), 256'(2));
    chk("vin_contiguous", 256'(last_vin_cyc - first_vin_cyc), 256'(N - 1));
    if (stuck) begin
      chk("timeout_writes", 256'(wr_cnt), 256'(0));
      chk("timeout_cycle", 256'(done_cyc - first_rd_cyc), 256'(N + TMO));
    end else begin
      chk("writes", 256'(wr_cnt), 256'(N));
      chk("done_after_last_wr", 256'(done_cyc - last_wr_cyc), 256'(1));
      chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    end
  endtask

  task automatic mid_job_cancel(input bit use_reset);
    clear_job();
    stub_stuck = 1'b0;
    stub_gap   = 0;
    stub_lat   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("cancel_point_addr", 256'(op_rd_addr), 256'(2));
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear",
          256'({busy, done, op_rd_en, sa_valid_in, res_wr_en, op_rd_addr, sa_a, sa_b}), 256'(0));
      repeat (3) tick();
      rst_n = 1'b1;
    end else begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_rd_en", 256'(op_rd_en), 256'(0));
      chk("abort_vin", 256'(sa_valid_in), 256'(0));
      chk("abort_busy", 256'(busy), 256'(0));
    end
    repeat (20) tick();
    chk("cancel_no_done", 256'(done_cnt), 256'(0));
    chk("cancel_no_write", 256'(wr_cnt), 256'(0));
    chk("cancel_reads", 256'(rd_cnt), 256'(3));
    chk("cancel_idle", 256'({busy, op_rd_en, sa_valid_in, res_wr_en}), 256'(0));
  endtask

  initial begin
    repeat (5) tick();
    chk("reset_outputs",
        256'({busy, done, timeout_err, op_rd_en, op_rd_addr, sa_valid_in, sa_a, sa_b,
              res_wr_en, res_wr_addr}), 256'(0));
    chk("reset_wr_data", 256'(res_wr_data), 256'(0));
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", 256'({busy, done, op_rd_en, sa_valid_in, res_wr_en}), 256'(0));

    // All-ones operands: every result element is N.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mem_a[i][j] = 1;
        mem_b[i][j] = 1;
      end
    run_job(1'b0, 0, 3, 1'b0);

    // Identity times B gives B; stray start while busy; started right after done.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mem_a[i][j] = (i == j) ? 1 : 0;
        mem_b[i][j] = i * N + j;
      end
    run_job(1'b0, 0, 2, 1'b1);

    // Array never answers.
    run_job(1'b1, 0, 0, 1'b0);

    // Random operands with a gapped result stream, then assorted random jobs.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mem_a[i][j] = $urandom_range(0, 65535);
          mem_b[i][j] = $urandom_range(0, 65535);
        end
      if (n == 0) run_job(1'b0, 2, 1, 1'b0);
      else        run_job(1'b0, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
    end

    mid_job_cancel(1'b0);
    mid_job_cancel(1'b1);

    // Recovery after cancellation.
    run_job(1'b0, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
